// File: rtl/count_monitor.sv
// count_monitor
//   Watches the value of an upstream 8-bit up/down counter. It does three jobs:
//   - pulses `wrap` for one cycle when the counter rolls over (FF->00 counting
//     up, or 00->FF counting down),
//   - keeps a saturating tally of those roll-overs in `wrap_cnt`,
//   - runs a small arm/hit FSM that pulses `match` once when the counter
//     reaches `cmp_val` after being armed.
//   Every output is registered. Inputs sampled at a rising edge show up on the
//   outputs right after that edge.
//
// Ports
//   clk      in   1  system clock, all state changes on its rising edge
//   reset    in   1  asynchronous reset, active low
//   count    in   8  counter value from upstream
//   up_down  in   1  counter direction (0 = up, 1 = down)
//   load     in   1  counter parallel load this cycle (count may jump)
//   cmp_val  in   8  compare value for match detection
//   arm      in   1  arm (or re-arm) match detection
//   clr      in   1  synchronous clear of FSM and wrap counter
//   match    out  1  one-cycle pulse on compare hit
//   wrap     out  1  one-cycle pulse on counter wrap-around
//   wrap_cnt out  8  saturating number of wrap events
//   state    out  2  FSM state (00 IDLE, 01 ARMED, 10 HIT)
module count_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  input  logic       up_down,
  input  logic       load,
  input  logic [7:0] cmp_val,
  input  logic       arm,
  input  logic       clr,
  output logic       match,
  output logic       wrap,
  output logic [7:0] wrap_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    HIT   = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic       match_q, match_d;
  logic       wrap_q;
  logic [7:0] wrap_cnt_q;
  logic [7:0] prev_count;
  logic       prev_valid;

  logic       wrap_cond;
  logic       hit_cond;

  // A roll-over needs a real previous sample to compare against. A load can
  // make the count jump to any value, so it never counts as a wrap.
  assign wrap_cond = prev_valid && !load &&
                     ((!up_down && prev_count == 8'hFF && count == 8'h00) ||
                      ( up_down && prev_count == 8'h00 && count == 8'hFF));

  // Match only on a count that has just changed (or on the very first sample).
  // That way a count sitting still at cmp_val fires once per arming, not on
  // every cycle.
  assign hit_cond = (count == cmp_val) &&
                    ((count != prev_count) || !prev_valid) && !load;

  // Next-state logic. clr wins over everything else.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and create a latch.
    state_d = state_q;
    match_d = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) state_d = ARMED;
        end
        ARMED: begin
          if (hit_cond) begin
            state_d = HIT;
            match_d = 1'b1;
          end
        end
        HIT: begin
          if (arm) state_d = ARMED;
        end
        default: state_d = IDLE;  // unused code 11 goes back to IDLE
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // each register sees the values that were present before the edge.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register here, prev_count included, is cleared by the async
    // reset. The first edge after reset is treated as the first sample.
    if (!reset) begin
      state_q    <= IDLE;
      match_q    <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= 8'h00;
      prev_count <= 8'h00;
      prev_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      wrap_q     <= wrap_cond;  // wrap is still reported in a clr cycle
      prev_count <= count;
      prev_valid <= 1'b1;
      if (clr)
        wrap_cnt_q <= 8'h00;
      else if (wrap_cond && wrap_cnt_q != 8'hFF)
        wrap_cnt_q <= wrap_cnt_q + 8'd1;
    end
  end

  assign match    = match_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign state    = state_q;

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 The block SHALL have ports clk, input, 1, single system clock (all state updates on its rising edge).
REQ-002 The block SHALL have ports reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 The block SHALL have ports count, input, 8, count value from the upstream up/down counter.
REQ-004 The block SHALL have ports up_down, input, 1, counter direction (0 = up, 1 = down).
REQ-005 The block SHALL have ports load, input, 1, counter parallel-load strobe (count discontinuity this cycle).
REQ-006 The block SHALL have ports cmp_val, input, 8, compare value for match detection.
REQ-007 The block SHALL have ports arm, input, 1, request to arm match detection.
REQ-008 The block SHALL have ports clr, input, 1, synchronous clear of FSM and wrap counter.
REQ-009 The block SHALL have ports match, output, 1, one-cycle pulse on compare hit.
REQ-010 The block SHALL have ports wrap, output, 1, one-cycle pulse on counter wrap-around.
REQ-011 The block SHALL have ports wrap_cnt, output, 8, saturating count of wrap events.
REQ-012 The block SHALL have ports state, output, 2, FSM state (00 IDLE, 01 ARMED, 10 HIT; 11 unused).

Function
REQ-013 All outputs SHALL be registered; inputs sampled at edge N affect outputs from edge N onward (one-cycle latency).
REQ-014 The block SHALL hold prev_count (count sampled at previous edge) and prev_valid (0 after reset, 1 after first edge).
REQ-015 Wrap condition SHALL be: prev_valid=1, load=0, and either (up_down=0, prev_count=FF, count=00) or (up_down=1, prev_count=00, count=FF).
REQ-016 wrap SHALL be 1 for exactly the cycle after each edge where the wrap condition holds, else 0.
REQ-017 wrap_cnt SHALL increment by 1 on each wrap condition and saturate at FF (no roll-over).
REQ-018 load=1 SHALL suppress wrap detection and match detection for that sample; prev_count SHALL still update.
REQ-019 FSM IDLE: arm=1 -> ARMED; else stay.
REQ-020 FSM ARMED: count=cmp_val and (count != prev_count or prev_valid=0) and load=0 -> HIT with match=1 for one cycle; else stay.
REQ-021 FSM HIT: arm=1 -> ARMED (re-arm, no match pulse that cycle); else stay; match=0 while in HIT.
REQ-022 A static count equal to cmp_val SHALL produce at most one match per arming.
REQ-023 clr=1 SHALL force state to IDLE, wrap_cnt to 00, match to 0, in any state; clr has priority over arm, match and wrap increment in the same cycle (wrap pulse itself still reported).
REQ-024 State code 11 SHALL recover to IDLE on the next edge.

Reset
REQ-025 reset=0 SHALL immediately (without clk) force state=IDLE, match=0, wrap=0, wrap_cnt=00, prev_count=00, prev_valid=0.
REQ-026 Reset asserted mid-operation (ARMED or HIT, wrap_cnt nonzero) SHALL discard all state; first edge after release SHALL be treated as the first sample (no wrap possible).

Verification
REQ-027 Up wrap: up_down=0, count steps FD,FE,FF,00,01 -> one wrap pulse the cycle after 00 sampled; wrap_cnt=01.
REQ-028 Down wrap and load: up_down=1, count 01,00,FF -> wrap, wrap_cnt+1; repeat with load=1 on the FF sample -> no wrap, wrap_cnt unchanged.
REQ-029 Match: cmp_val=39, arm pulse, count 37,38,39,39,3A -> state ARMED then HIT, exactly one match pulse after first 39; arm again while count=39 static -> ARMED, no match.
REQ-030 Saturation and clr: force 300 wraps -> wrap_cnt=FF; clr=1 with simultaneous wrap condition -> wrap pulse, wrap_cnt=00, state=IDLE.
REQ-031 Priority: in IDLE assert arm and clr together -> state stays IDLE; in ARMED with count=cmp_val and clr=1 -> no match, IDLE.
REQ-032 Async reset: in HIT with wrap_cnt=05, drop reset between edges -> outputs zero before next edge; release, then count=00 after previous FF -> no wrap on first sample.
